// File: rtl/vga_capture_monitor_if.sv
// Video capture bundle between a VGA-style source and the capture monitor.
// The source (master) drives sync, colour and the pixel-rate enable; the monitor (slave) returns capture and status.
interface vga_capture_monitor_if;
    logic        PIX_EN;
    logic        HS;
    logic        VS;
    logic [11:0] COLOUR_IN;
    logic        PIX_VALID;
    logic [9:0]  ADDRH;
    logic [8:0]  ADDRV;
    logic [11:0] PIX_COLOUR;
    logic        LINE_DONE;
    logic        FRAME_DONE;
    logic        LOCKED;
    logic        HS_ERR;
    logic        VS_ERR;

    modport master (
        output PIX_EN, HS, VS, COLOUR_IN,
        input  PIX_VALID, ADDRH, ADDRV, PIX_COLOUR,
        input  LINE_DONE, FRAME_DONE, LOCKED, HS_ERR, VS_ERR
    );

    modport slave (
        input  PIX_EN, HS, VS, COLOUR_IN,
        output PIX_VALID, ADDRH, ADDRV, PIX_COLOUR,
        output LINE_DONE, FRAME_DONE, LOCKED, HS_ERR, VS_ERR
    );
endinterface

// File: rtl/vga_capture_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from sync edges, checks sync timing, locks onto the stream.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_SEARCH | no frame reference yet; wait for the first frame-start
// S_ALIGN  | timing one full frame; a clean frame leads to lock
// S_LOCKED | stream trusted; active pixels are reported
module vga_capture_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 31,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 521
) (
    input  logic                  CLK,
    input  logic                  RESET,
    vga_capture_monitor_if.slave  vid
);
    localparam logic [9:0] CNT_MAX  = '1;
    localparam logic [9:0] HT_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_WIDTH = 10'(H_SYNC);
    localparam logic [9:0] HA_START = 10'(H_ACT_START);
    localparam logic [9:0] HA_END   = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] HA_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] VT_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_WIDTH = 10'(V_SYNC);
    localparam logic [9:0] VA_START = 10'(V_ACT_START);
    localparam logic [9:0] VA_END   = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [8:0] VA_LAST  = 9'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [9:0] hcnt, vcnt, hlow, vlow;
    logic       hs_q, vs_q;
    logic       seen_h, seen_v, vs_pend, frame_err;

    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       frame_start;
    logic [9:0] hcnt_next, vcnt_next, hlow_next, vlow_next;
    logic       vs_pend_next, frame_err_next;
    logic       hs_err_c, vs_err_c, any_err;
    logic       active, capture;
    logic [9:0] addrh_next;
    logic [8:0] addrv_next;

    assign hs_fall = ~vid.HS & hs_q;
    assign hs_rise =  vid.HS & ~hs_q;
    assign vs_fall = ~vid.VS & vs_q;
    assign vs_rise =  vid.VS & ~vs_q;

    // A VS edge anywhere in a line is only acted on at the next HS falling edge.
    assign frame_start = hs_fall & (vs_pend | vs_fall);

    always_comb begin
        hcnt_next    = hcnt;
        hlow_next    = hlow;
        vcnt_next    = vcnt;
        vlow_next    = vlow;
        vs_pend_next = vs_pend;

        if (hs_fall) begin
            hcnt_next = '0;
        end else if (hcnt != CNT_MAX) begin
            hcnt_next = hcnt + 10'd1;
        end

        if (hs_fall) begin
            hlow_next = 10'd1;
        end else if (!vid.HS && hlow != CNT_MAX) begin
            hlow_next = hlow + 10'd1;
        end

        if (frame_start) begin
            vcnt_next = '0;
        end else if (hs_fall && vcnt != CNT_MAX) begin
            vcnt_next = vcnt + 10'd1;
        end

        if (frame_start) begin
            vlow_next = vid.VS ? 10'd0 : 10'd1;
        end else if (vs_fall) begin
            vlow_next = '0;
        end else if (hs_fall && !vid.VS && vlow != CNT_MAX) begin
            vlow_next = vlow + 10'd1;
        end

        if (frame_start) begin
            vs_pend_next = 1'b0;
        end else if (vs_fall) begin
            vs_pend_next = 1'b1;
        end
    end

    assign hs_err_c = seen_h & ((hs_fall & (hcnt != HT_LAST)) |
                                (hs_rise & (hlow != HS_WIDTH)));
    assign vs_err_c = seen_v & ((frame_start & (vcnt != VT_LAST)) |
                                (vs_rise & (vlow != VS_WIDTH)));
    assign any_err  = hs_err_c | vs_err_c;

    assign active     = (hcnt_next >= HA_START) && (hcnt_next < HA_END) &&
                        (vcnt >= VA_START) && (vcnt < VA_END);
    assign capture    = active && (state == S_LOCKED);
    assign addrh_next = hcnt_next - HA_START;
    assign addrv_next = 9'(vcnt - VA_START);

    // An error on the deciding frame-start belongs to the frame just ending, so it blocks lock.
    always_comb begin
        state_next     = state;
        frame_err_next = frame_err;
        case (state)
            S_SEARCH: begin
                if (frame_start) begin
                    state_next     = S_ALIGN;
                    frame_err_next = 1'b0;
                end
            end
            S_ALIGN: begin
                if (frame_start) begin
                    if (!frame_err && !any_err) begin
                        state_next = S_LOCKED;
                    end
                    frame_err_next = 1'b0;
                end else if (any_err) begin
                    frame_err_next = 1'b1;
                end
            end
            S_LOCKED: begin
                if (any_err) begin
                    state_next = S_SEARCH;
                end
            end
            default: begin
                state_next     = S_SEARCH;
                frame_err_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_SEARCH;
            frame_err      <= 1'b0;
            hcnt           <= '0;
            vcnt           <= '0;
            hlow           <= '0;
            vlow           <= '0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            seen_h         <= 1'b0;
            seen_v         <= 1'b0;
            vs_pend        <= 1'b0;
            vid.PIX_VALID  <= 1'b0;
            vid.ADDRH      <= '0;
            vid.ADDRV      <= '0;
            vid.PIX_COLOUR <= '0;
            vid.LINE_DONE  <= 1'b0;
            vid.FRAME_DONE <= 1'b0;
            vid.LOCKED     <= 1'b0;
            vid.HS_ERR     <= 1'b0;
            vid.VS_ERR     <= 1'b0;
        end else begin
            vid.PIX_VALID  <= 1'b0;
            vid.LINE_DONE  <= 1'b0;
            vid.FRAME_DONE <= 1'b0;
            vid.HS_ERR     <= 1'b0;
            vid.VS_ERR     <= 1'b0;
            if (vid.PIX_EN) begin
                state     <= state_next;
                frame_err <= frame_err_next;
                hcnt      <= hcnt_next;
                vcnt      <= vcnt_next;
                hlow      <= hlow_next;
                vlow      <= vlow_next;
                hs_q      <= vid.HS;
                vs_q      <= vid.VS;
                vs_pend   <= vs_pend_next;
                if (hs_fall) begin
                    seen_h <= 1'b1;
                end
                if (frame_start) begin
                    seen_v <= 1'b1;
                end
                vid.PIX_VALID  <= capture;
                vid.LINE_DONE  <= capture && (addrh_next == HA_LAST);
                vid.FRAME_DONE <= capture && (addrh_next == HA_LAST) &&
                                  (addrv_next == VA_LAST);
                if (capture) begin
                    vid.ADDRH      <= addrh_next;
                    vid.ADDRV      <= addrv_next;
                    vid.PIX_COLOUR <= vid.COLOUR_IN;
                end
                vid.HS_ERR <= hs_err_c;
                vid.VS_ERR <= vs_err_c;
                vid.LOCKED <= (state_next == S_LOCKED);
            end
        end
    end
endmodule
